// File: rtl/signal_switch_n.sv
// -----------------------------------------------------------------------------
// signal_switch_n
// Registered N-to-1 sample selector for the Vibrometer signal path. One of
// CHANNEL_COUNT equal-width streams is routed to data_out. Every channel change
// blanks the output to zero for BLANK_CYCLES cycles so that downstream filters
// never see a step between unrelated sources.
//
// Ports
//   SYS_aclk        in   system clock, rising edge
//   SYS_aresetn     in   asynchronous active-low reset
//   select          in   requested channel, sampled every cycle
//   data_in         in   packed channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_out        out  registered selected sample (0 while blanked)
//   data_valid      out  1 = data_out carries active_channel
//   active_channel  out  channel currently routed (or being settled to)
//   switch_done     out  one-cycle pulse when a switch completes
//   select_error    out  sticky flag: out-of-range select seen in RUN
// -----------------------------------------------------------------------------
module signal_switch_n #(
  parameter int DATA_WIDTH    = 16,
  parameter int CHANNEL_COUNT = 4,
  parameter int SEL_WIDTH     = 2,
  parameter int BLANK_CYCLES  = 4
) (
  input  logic                                SYS_aclk,
  input  logic                                SYS_aresetn,
  input  logic [SEL_WIDTH-1:0]                select,
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_valid,
  output logic [SEL_WIDTH-1:0]                active_channel,
  output logic                                switch_done,
  output logic                                select_error
);

  localparam int CNT_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int CNT_LOAD = (BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [SEL_WIDTH:0] CH_COUNT_L = (SEL_WIDTH + 1)'(CHANNEL_COUNT);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        blank_cnt_r;
  logic [DATA_WIDTH-1:0]   data_out_r;
  logic                    data_valid_r;
  logic [SEL_WIDTH-1:0]    active_channel_r;
  logic                    switch_done_r;
  logic                    select_error_r;

  logic [DATA_WIDTH-1:0]   cur_data_s;
  logic [DATA_WIDTH-1:0]   new_data_s;
  logic                    sel_in_range_s;
  logic                    sel_differs_s;

  // Mux one channel out of the packed bus; indices beyond the channel count yield zero.
  function automatic logic [DATA_WIDTH-1:0] pick_channel(
    input logic [CHANNEL_COUNT*DATA_WIDTH-1:0] bus,
    input logic [SEL_WIDTH-1:0]                idx
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < CHANNEL_COUNT; k++) begin
      if (idx == SEL_WIDTH'(k)) begin
        res = bus[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Decode the current and requested channel samples and classify the select.
  always_comb begin
    cur_data_s     = pick_channel(data_in, active_channel_r);
    new_data_s     = pick_channel(data_in, select);
    sel_in_range_s = ({1'b0, select} < CH_COUNT_L);
    sel_differs_s  = (select != active_channel_r);
  end

  // Run/blank sequencer with all outputs registered.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state_r          <= ST_RUN;
      blank_cnt_r      <= '0;
      data_out_r       <= '0;
      data_valid_r     <= 1'b0;
      active_channel_r <= '0;
      switch_done_r    <= 1'b0;
      select_error_r   <= 1'b0;
    end else begin
      switch_done_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (!sel_in_range_s) begin
            // Bad select: keep routing the current channel, just flag it.
            select_error_r <= 1'b1;
            data_out_r     <= cur_data_s;
            data_valid_r   <= 1'b1;
          end else if (sel_differs_s) begin
            active_channel_r <= select;
            if (HAS_BLANK) begin
              data_out_r   <= '0;
              data_valid_r <= 1'b0;
              blank_cnt_r  <= CNT_W'(CNT_LOAD);
              state_r      <= ST_BLANK;
            end else begin
              // No settle time: new channel lands on this very edge.
              data_out_r    <= new_data_s;
              data_valid_r  <= 1'b1;
              switch_done_r <= 1'b1;
            end
          end else begin
            data_out_r   <= cur_data_s;
            data_valid_r <= 1'b1;
          end
        end
        ST_BLANK: begin
          // select is deliberately ignored here; it is re-examined once back in RUN.
          if (blank_cnt_r != '0) begin
            blank_cnt_r  <= blank_cnt_r - CNT_W'(1);
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
          end else begin
            state_r       <= ST_RUN;
            data_out_r    <= cur_data_s;
            data_valid_r  <= 1'b1;
            switch_done_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_RUN;
          blank_cnt_r  <= '0;
          data_out_r   <= '0;
          data_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_out       = data_out_r;
  assign data_valid     = data_valid_r;
  assign active_channel = active_channel_r;
  assign switch_done    = switch_done_r;
  assign select_error   = select_error_r;

endmodule

// File: tb/tb_signal_switch_n.sv
// -----------------------------------------------------------------------------
// tb_signal_switch_n
// Two instances share clock, reset and data: unit A (SEL_WIDTH=3, 4 channels,
// 4 blank cycles) and unit B (SEL_WIDTH=2, 4 channels, no blanking). A
// behavioural model tracks "zero cycles still owed" per unit and predicts
// every output after each rising edge.
// -----------------------------------------------------------------------------
module tb_signal_switch_n;

  localparam int DW = 16;
  localparam int CC = 4;

  logic              clk;
  logic              rst_n;
  logic [2:0]        sel_a;
  logic [1:0]        sel_b;
  logic [CC*DW-1:0]  din;

  logic [DW-1:0]     dout_a, dout_b;
  logic              valid_a, valid_b;
  logic [2:0]        act_a;
  logic [1:0]        act_b;
  logic              done_a, done_b;
  logic              err_a, err_b;

  int n_checks;
  int n_errors;

  // Model state, index 0 = unit A, 1 = unit B
  int          m_active [2];
  int          m_left   [2];
  logic [15:0] m_out    [2];
  bit          m_valid  [2];
  bit          m_done   [2];
  bit          m_err    [2];
  int          m_blank  [2];

  signal_switch_n #(.DATA_WIDTH(DW), .CHANNEL_COUNT(CC), .SEL_WIDTH(3), .BLANK_CYCLES(4)) u_a (
    .SYS_aclk(clk), .SYS_aresetn(rst_n), .select(sel_a), .data_in(din),
    .data_out(dout_a), .data_valid(valid_a), .active_channel(act_a),
    .switch_done(done_a), .select_error(err_a)
  );

  signal_switch_n #(.DATA_WIDTH(DW), .CHANNEL_COUNT(CC), .SEL_WIDTH(2), .BLANK_CYCLES(0)) u_b (
    .SYS_aclk(clk), .SYS_aresetn(rst_n), .select(sel_b), .data_in(din),
    .data_out(dout_b), .data_valid(valid_b), .active_channel(act_b),
    .switch_done(done_b), .select_error(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] chan(input int k);
    return din[k*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_active[u] = 0; m_left[u] = 0; m_out[u] = 16'h0000;
      m_valid[u] = 1'b0; m_done[u] = 1'b0; m_err[u] = 1'b0;
    end
  endtask

  // One rising edge worth of behaviour, from the selector's rules.
  task automatic model_edge(input int u, input int s);
    m_done[u] = 1'b0;
    if (m_left[u] > 0) begin
      m_left[u]--;
      if (m_left[u] == 0) begin
        m_out[u] = chan(m_active[u]); m_valid[u] = 1'b1; m_done[u] = 1'b1;
      end else begin
        m_out[u] = 16'h0000; m_valid[u] = 1'b0;
      end
    end else if (s >= CC) begin
      m_err[u] = 1'b1; m_out[u] = chan(m_active[u]); m_valid[u] = 1'b1;
    end else if (s != m_active[u]) begin
      m_active[u] = s;
      if (m_blank[u] > 0) begin
        m_left[u] = m_blank[u]; m_out[u] = 16'h0000; m_valid[u] = 1'b0;
      end else begin
        m_out[u] = chan(s); m_valid[u] = 1'b1; m_done[u] = 1'b1;
      end
    end else begin
      m_out[u] = chan(m_active[u]); m_valid[u] = 1'b1;
    end
  endtask

  task automatic compare_all();
    chk("a_out",   32'(dout_a),  32'(m_out[0]));
    chk("a_valid", 32'(valid_a), 32'(m_valid[0]));
    chk("a_act",   32'(act_a),   32'(m_active[0]));
    chk("a_done",  32'(done_a),  32'(m_done[0]));
    chk("a_err",   32'(err_a),   32'(m_err[0]));
    chk("b_out",   32'(dout_b),  32'(m_out[1]));
    chk("b_valid", 32'(valid_b), 32'(m_valid[1]));
    chk("b_act",   32'(act_b),   32'(m_active[1]));
    chk("b_done",  32'(done_b),  32'(m_done[1]));
    chk("b_err",   32'(err_b),   32'(m_err[1]));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      model_edge(0, int'(sel_a));
      model_edge(1, int'(sel_b));
    end
    #1;
    compare_all();
  endtask

  int pulses;

  initial begin
    n_checks = 0; n_errors = 0;
    m_blank[0] = 4; m_blank[1] = 0;
    rst_n = 1'b0; sel_a = 3'd0; sel_b = 2'd0; din = '0;
    din[0*DW +: DW] = 16'd14;
    din[1*DW +: DW] = 16'hFFE3;
    din[2*DW +: DW] = 16'd200;
    din[3*DW +: DW] = 16'h8001;
    model_reset();
    #12;
    compare_all();

    // First edge after release routes channel 0
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("t1_out", 32'(dout_a), 32'd14);
    chk("t1_done", 32'(done_a), 32'd0);

    // Switch 0->1: A blanks 4 cycles, B switches at once
    sel_a = 3'd1; sel_b = 2'd1;
    step();
    chk("t2_a_zero", 32'(dout_a), 32'd0);
    chk("z_out", 32'(dout_b), 32'h0000FFE3);
    chk("z_valid", 32'(valid_b), 32'd1);
    chk("z_done", 32'(done_b), 32'd1);
    step(); step(); step();
    chk("t2_a_still_zero", 32'(valid_a), 32'd0);
    step();
    chk("t2_a_new", 32'(dout_a), 32'h0000FFE3);
    chk("t2_a_done", 32'(done_a), 32'd1);
    step();
    chk("t2_a_done_low", 32'(done_a), 32'd0);

    // Data change while running passes straight through
    din[1*DW +: DW] = 16'd16;
    step();
    chk("t3_out", 32'(dout_a), 32'd16);

    // Reselect inside a blank: two back-to-back blank intervals
    sel_a = 3'd2;
    pulses = 0;
    step(); pulses += int'(done_a);
    step(); pulses += int'(done_a);
    sel_a = 3'd3;
    for (int i = 0; i < 10; i++) begin
      step(); pulses += int'(done_a);
    end
    chk("t4_pulses", 32'(pulses), 32'd2);
    chk("t4_act", 32'(act_a), 32'd3);

    // Out-of-range select is sticky and does not switch
    sel_a = 3'd5;
    step(); step();
    chk("t5_err", 32'(err_a), 32'd1);
    chk("t5_act", 32'(act_a), 32'd3);
    sel_a = 3'd0;
    for (int i = 0; i < 6; i++) step();
    chk("t5_err_sticky", 32'(err_a), 32'd1);

    // Reset in the middle of a blank
    sel_a = 3'd1;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("t6_err_clr", 32'(err_a), 32'd0);
    @(negedge clk); rst_n = 1'b1; sel_a = 3'd0; sel_b = 2'd0;
    step();
    chk("t6_out", 32'(dout_a), 32'(din[0 +: DW]));
    chk("t6_no_done", 32'(done_a), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      din = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) sel_a = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) sel_b = 2'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
